// File: rtl/exp_arbiter.sv
// -----------------------------------------------------------------------------
// exp_arbiter
//
// Round-robin arbiter and sequencer that shares one exponential-series engine
// among N_REQ requesters. For each granted request it latches the operand,
// pulses the engine start for one cycle, follows the engine done indicator
// (high = idle, low = computing), and returns the registered result to the
// winner with a one-cycle ack.
//
// Optional feature macro: EXP_ARB_TIMEOUT_EN
//   defined   : a watchdog counts cycles spent in WAIT_LO/WAIT_HI; at
//               TO_CYCLES the service is finished with err=1, result=0.
//   undefined : no counter is built, err is tied low, waits are unbounded.
//
// Parameters
//   N_REQ     number of requesters (>= 2)
//   XW        operand width
//   RW        result width
//   TO_CYCLES watchdog limit in cycles (timeout builds only)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   req        in   [N_REQ]     request levels, held with x_in until ack
//   x_in       in   [N_REQ*XW]  packed operands, requester i at [i*XW +: XW]
//   grant      out  [N_REQ]     one-hot grant, held from START through RESP
//   ack        out  [N_REQ]     one-cycle pulse on the granted bit in RESP
//   result     out  [RW]        registered engine result, holds until next RESP
//   err        out              timeout flag, valid with ack
//   busy       out              high in every state except IDLE
//   eng_start  out              engine start, high for the START cycle only
//   eng_x      out  [XW]        latched operand for the engine
//   eng_done   in               engine idle/done indicator
//   eng_result in   [RW]        engine result
//
// Handshake: a requester raises req with its operand on x_in and holds both
// until it sees its ack bit. req is only looked at in IDLE, so a request
// raised while another is in service waits; lowering req mid-service does not
// abort the engine and the ack is still pulsed. All outputs are registers or
// decodes of the state register; there is no combinational req->grant path.
//
// The FSM state register is named ps and the round-robin pointer ptr so both
// can be observed hierarchically.
// -----------------------------------------------------------------------------
module exp_arbiter #(
  parameter int N_REQ     = 4,
  parameter int XW        = 16,
  parameter int RW        = 16,
  parameter int TO_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*XW-1:0] x_in,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    ack,
  output logic [RW-1:0]       result,
  output logic                err,
  output logic                busy,
  output logic                eng_start,
  output logic [XW-1:0]       eng_x,
  input  logic                eng_done,
  input  logic [RW-1:0]       eng_result
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t ps;
  state_t ns;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;

  // Round-robin selection (combinational, from registered ptr and req)
  logic [PTR_W:0]   cand;
  logic [PTR_W-1:0] sel_idx;
  logic [N_REQ-1:0] sel_oh;
  logic [XW-1:0]    sel_x;
  logic             sel_valid;
  logic             accept;
  logic             timeout;

  // Scan indices ptr, ptr+1, ... wrapping modulo N_REQ; the first asserted
  // request wins. cand has one spare bit so ptr+k never overflows before the
  // modulo subtraction.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_oh    = '0;
    sel_x     = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(N_REQ)) begin
        cand = cand - (PTR_W+1)'(N_REQ);
      end
      if (!sel_valid && req[cand[PTR_W-1:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = cand[PTR_W-1:0];
      end
    end
    sel_oh[sel_idx] = sel_valid;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_oh[i]) begin
        sel_x = x_in[i*XW +: XW];
      end
    end
  end

  // A new service only starts when the engine reports idle.
  assign accept = sel_valid && eng_done;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ps <= IDLE;
    end else begin
      ps <= ns;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    ns = ps;
    case (ps)
      IDLE: begin
        if (accept) ns = START;
      end
      START: begin
        ns = WAIT_LO;
      end
      WAIT_LO: begin
        // Timeout is checked first so a counter that reaches its limit here is
        // never skipped past by a late done drop.
        if (timeout) begin
          ns = RESP;
        end else if (!eng_done) begin
          ns = WAIT_HI;
        end
      end
      WAIT_HI: begin
        // A real completion wins over a simultaneous timeout.
        if (eng_done || timeout) ns = RESP;
      end
      RESP: begin
        ns = IDLE;
      end
      default: begin
        ns = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: grant, operand, result, pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      grant     <= '0;
      grant_idx <= '0;
      eng_x     <= '0;
      result    <= '0;
    end else begin
      case (ps)
        IDLE: begin
          if (accept) begin
            grant     <= sel_oh;
            grant_idx <= sel_idx;
            eng_x     <= sel_x;
          end
        end
        WAIT_LO: begin
          if (timeout) result <= '0;
        end
        WAIT_HI: begin
          if (eng_done) begin
            result <= eng_result;
          end else if (timeout) begin
            result <= '0;
          end
        end
        RESP: begin
          grant <= '0;
          if (grant_idx == PTR_W'(N_REQ - 1)) begin
            ptr <= '0;
          end else begin
            ptr <= grant_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef EXP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] to_cnt;
  logic          in_wait;

  assign in_wait = (ps == WAIT_LO) || (ps == WAIT_HI);
  // to_cnt holds the number of wait cycles already completed, so the limit is
  // hit on the TO_CYCLES-th wait cycle and RESP follows immediately.
  assign timeout = in_wait && (to_cnt == CW'(TO_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (ps == IDLE && accept) begin
        to_cnt <= '0;
      end else if (in_wait) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (ps == WAIT_HI && eng_done) begin
        err <= 1'b0;
      end else if (timeout) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic unused_cfg;

  assign timeout    = 1'b0;
  assign err        = 1'b0;
  assign unused_cfg = (TO_CYCLES == 0);
`endif

  // ---------------------------------------------------------------------------
  // State decodes
  // ---------------------------------------------------------------------------
  assign busy      = (ps != IDLE);
  assign eng_start = (ps == START);
  assign ack       = (ps == RESP) ? grant : '0;

endmodule

// File: tb/tb_exp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_exp_arbiter
//
// Directed bench for exp_arbiter with a behavioural engine model. The engine
// drops done on the edge that samples eng_start, stays busy for eng_lat
// cycles, then raises done with result = operand ^ 16'hAACD (so operand 0x0100
// yields 0xABCD). eng_hang keeps it busy until reset; force_low masks done.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_exp_arbiter;

  localparam int N_REQ     = 4;
  localparam int XW        = 16;
  localparam int RW        = 16;
  localparam int TO_CYCLES = 20;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N_REQ-1:0]    req = '0;
  logic [N_REQ*XW-1:0] x_in = '0;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    ack;
  logic [RW-1:0]       result;
  logic                err;
  logic                busy;
  logic                eng_start;
  logic [XW-1:0]       eng_x;
  logic                eng_done;
  logic [RW-1:0]       eng_result;

  always #5 clk = ~clk;

  exp_arbiter #(
    .N_REQ    (N_REQ),
    .XW       (XW),
    .RW       (RW),
    .TO_CYCLES(TO_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .x_in      (x_in),
    .grant     (grant),
    .ack       (ack),
    .result    (result),
    .err       (err),
    .busy      (busy),
    .eng_start (eng_start),
    .eng_x     (eng_x),
    .eng_done  (eng_done),
    .eng_result(eng_result)
  );

  // ---------------------------------------------------------------------------
  // Engine model
  // ---------------------------------------------------------------------------
  logic        done_r;
  logic        eng_busy;
  int          eng_cnt;
  logic [15:0] eng_xl;
  int          eng_lat   = 10;
  bit          eng_hang  = 1'b0;
  bit          force_low = 1'b0;

  function automatic logic [15:0] model_res(input logic [15:0] x);
    return x ^ 16'hAACD;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      eng_busy   <= 1'b0;
      done_r     <= 1'b1;
      eng_result <= '0;
      eng_cnt    <= 0;
      eng_xl     <= '0;
    end else if (!eng_busy) begin
      if (eng_start) begin
        eng_busy <= 1'b1;
        done_r   <= 1'b0;
        eng_cnt  <= eng_lat;
        eng_xl   <= eng_x;
      end
    end else if (!eng_hang) begin
      if (eng_cnt <= 1) begin
        eng_busy   <= 1'b0;
        done_r     <= 1'b1;
        eng_result <= model_res(eng_xl);
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  assign eng_done = done_r & ~force_low;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  logic [15:0] exp_q[$];
  int          exp_idx_q[$];

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Advance until some ack bit is seen (returns inside the RESP cycle).
  task automatic wait_ack(input int limit, output int ncyc, output bit ok);
    ok   = 1'b0;
    ncyc = 0;
    for (int i = 0; i < limit; i++) begin
      cyc();
      ncyc++;
      if (ack !== '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    req = '0;
    rst = 1'b1;
    cyc();
    cyc();
    chk_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %0b want 0", busy); end else pass_cnt++;
    chk_cnt++; if (grant !== 4'b0) begin fail_cnt++; $display("FAIL reset_grant: got %b want 0000", grant); end else pass_cnt++;
    chk_cnt++; if (ack !== 4'b0) begin fail_cnt++; $display("FAIL reset_ack: got %b want 0000", ack); end else pass_cnt++;
    chk_cnt++; if (eng_start !== 1'b0) begin fail_cnt++; $display("FAIL reset_eng_start: got %0b want 0", eng_start); end else pass_cnt++;
    chk_cnt++; if (err !== 1'b0) begin fail_cnt++; $display("FAIL reset_err: got %0b want 0", err); end else pass_cnt++;
    chk_cnt++; if (result !== 16'h0) begin fail_cnt++; $display("FAIL reset_result: got %h want 0000", result); end else pass_cnt++;
    chk_cnt++; if (eng_x !== 16'h0) begin fail_cnt++; $display("FAIL reset_eng_x: got %h want 0000", eng_x); end else pass_cnt++;
    chk_cnt++; if (dut.ptr !== 2'd0) begin fail_cnt++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr); end else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int          n_start    = 0;
    int          n_ack      = 0;
    int          n_gbad     = 0;
    int          n_xbad     = 0;
    int          rise       = -1;
    int          ack_at     = -1;
    bit          saw_low    = 1'b0;
    logic [3:0]  a_at       = 'x;
    logic [15:0] r_at       = 'x;
    logic        e_at       = 1'bx;
    logic        busy_after = 1'bx;
    x_in = '0;
    x_in[2*16 +: 16] = 16'h0100;
    req = 4'b0100;
    eng_lat = 10;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      if (eng_start) n_start++;
      if (busy && grant !== 4'b0100) n_gbad++;
      if (busy && eng_x !== 16'h0100) n_xbad++;
      if (!eng_done) saw_low = 1'b1;
      else if (saw_low && rise < 0) rise = n;
      if (ack_at > 0 && n == ack_at + 1) busy_after = busy;
      if (ack !== '0) begin
        n_ack++;
        if (ack_at < 0) begin
          ack_at = n;
          a_at = ack;
          r_at = result;
          e_at = err;
          req = '0;
        end
      end
    end
    chk_cnt++; if (n_start != 1) begin fail_cnt++; $display("FAIL single_start_pulses: got %0d want 1", n_start); end else pass_cnt++;
    chk_cnt++; if (n_ack != 1) begin fail_cnt++; $display("FAIL single_ack_pulses: got %0d want 1", n_ack); end else pass_cnt++;
    chk_cnt++; if (n_gbad != 0) begin fail_cnt++; $display("FAIL single_grant: %0d busy cycles without grant 0100", n_gbad); end else pass_cnt++;
    chk_cnt++; if (n_xbad != 0) begin fail_cnt++; $display("FAIL single_eng_x: %0d busy cycles without eng_x 0100", n_xbad); end else pass_cnt++;
    chk_cnt++; if (a_at !== 4'b0100) begin fail_cnt++; $display("FAIL single_ack: got %b want 0100", a_at); end else pass_cnt++;
    chk_cnt++; if (r_at !== 16'hABCD) begin fail_cnt++; $display("FAIL single_result: got %h want abcd", r_at); end else pass_cnt++;
    chk_cnt++; if (e_at !== 1'b0) begin fail_cnt++; $display("FAIL single_err: got %0b want 0", e_at); end else pass_cnt++;
    chk_cnt++; if (rise < 0 || ack_at != rise + 1) begin fail_cnt++; $display("FAIL single_ack_timing: ack cycle %0d want done-rise cycle %0d + 1", ack_at, rise); end else pass_cnt++;
    chk_cnt++; if (busy_after !== 1'b0) begin fail_cnt++; $display("FAIL single_busy_after: got %0b want 0", busy_after); end else pass_cnt++;
  endtask

  task automatic test_all_four();
    int         last_ack = -1;
    int         acks     = 0;
    int         idx;
    logic [3:0] oh;
    logic [15:0] e;
    for (int i = 0; i < N_REQ; i++) x_in[i*16 +: 16] = 16'h1111 * 16'(i + 1);
    req = 4'b1111;
    eng_lat = 3;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      exp_idx_q.push_back(k % N_REQ);
      exp_q.push_back(model_res(16'h1111 * 16'((k % N_REQ) + 1)));
    end
    for (int n = 1; n <= 200; n++) begin
      cyc();
      if (eng_start && last_ack >= 0) begin
        chk_cnt++; if (n != last_ack + 2) begin fail_cnt++; $display("FAIL b2b_gap: start at %0d want %0d", n, last_ack + 2); end else pass_cnt++;
      end
      if (ack !== '0) begin
        idx = exp_idx_q.pop_front();
        e = exp_q.pop_front();
        oh = 4'b0001 << idx;
        chk_cnt++; if (ack !== oh) begin fail_cnt++; $display("FAIL b2b_order: ack %0d got %b want %b", acks, ack, oh); end else pass_cnt++;
        chk_cnt++; if (result !== e) begin fail_cnt++; $display("FAIL b2b_result: ack %0d got %h want %h", acks, result, e); end else pass_cnt++;
        last_ack = n;
        acks++;
        if (acks == 5) begin
          req = '0;
          break;
        end
      end
    end
    chk_cnt++; if (acks != 5) begin fail_cnt++; $display("FAIL b2b_ack_count: got %0d want 5", acks); end else pass_cnt++;
    cyc();
  endtask

  task automatic test_wrap();
    int ncyc;
    bit ok;
    eng_lat = 4;
    // ptr is 1 after the previous test; serving requester 1 moves it to 2.
    req = 4'b0010;
    wait_ack(100, ncyc, ok);
    chk_cnt++; if (ack !== 4'b0010) begin fail_cnt++; $display("FAIL wrap_setup_ack: got %b want 0010", ack); end else pass_cnt++;
    req = '0;
    cyc();
    chk_cnt++; if (dut.ptr !== 2'd2) begin fail_cnt++; $display("FAIL wrap_ptr_start: got %0d want 2", dut.ptr); end else pass_cnt++;
    req = 4'b1010;
    wait_ack(100, ncyc, ok);
    chk_cnt++; if (ack !== 4'b1000) begin fail_cnt++; $display("FAIL wrap_first: got %b want 1000", ack); end else pass_cnt++;
    chk_cnt++; if (result !== model_res(16'h4444)) begin fail_cnt++; $display("FAIL wrap_first_result: got %h want %h", result, model_res(16'h4444)); end else pass_cnt++;
    req = 4'b0010;
    wait_ack(100, ncyc, ok);
    chk_cnt++; if (ack !== 4'b0010) begin fail_cnt++; $display("FAIL wrap_second: got %b want 0010", ack); end else pass_cnt++;
    req = '0;
    cyc();
    chk_cnt++; if (dut.ptr !== 2'd2) begin fail_cnt++; $display("FAIL wrap_ptr_end: got %0d want 2", dut.ptr); end else pass_cnt++;
  endtask

  task automatic test_done_low();
    int n_bad = 0;
    int ncyc;
    bit ok;
    x_in[0 +: 16] = 16'h0F0F;
    eng_lat = 5;
    force_low = 1'b1;
    req = 4'b0001;
    for (int n = 0; n < 8; n++) begin
      cyc();
      if (grant !== '0 || eng_start !== 1'b0 || busy !== 1'b0) n_bad++;
    end
    chk_cnt++; if (n_bad != 0) begin fail_cnt++; $display("FAIL done_low_hold: %0d cycles with activity, want 0", n_bad); end else pass_cnt++;
    force_low = 1'b0;
    wait_ack(100, ncyc, ok);
    chk_cnt++; if (!ok) begin fail_cnt++; $display("FAIL done_low_wait: no ack within %0d cycles", ncyc); end else pass_cnt++;
    chk_cnt++; if (ack !== 4'b0001) begin fail_cnt++; $display("FAIL done_low_ack: got %b want 0001", ack); end else pass_cnt++;
    chk_cnt++; if (result !== 16'hA5C2) begin fail_cnt++; $display("FAIL done_low_result: got %h want a5c2", result); end else pass_cnt++;
    req = '0;
    cyc();
  endtask

  task automatic test_reset_mid();
    bit in_hi = 1'b0;
    int n_ack = 0;
    x_in[16 +: 16] = 16'h2222;
    eng_lat = 20;
    req = 4'b0010;
    for (int n = 0; n < 15; n++) begin
      cyc();
      if (dut.ps == 3'd3) begin
        in_hi = 1'b1;
        break;
      end
    end
    chk_cnt++; if (!in_hi) begin fail_cnt++; $display("FAIL rst_mid_reach_wait_hi: state %0d want 3", dut.ps); end else pass_cnt++;
    cyc();
    rst = 1'b1;
    req = '0;
    cyc();
    chk_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL rst_mid_busy: got %0b want 0", busy); end else pass_cnt++;
    chk_cnt++; if (grant !== 4'b0) begin fail_cnt++; $display("FAIL rst_mid_grant: got %b want 0000", grant); end else pass_cnt++;
    chk_cnt++; if (dut.ptr !== 2'd0) begin fail_cnt++; $display("FAIL rst_mid_ptr: got %0d want 0", dut.ptr); end else pass_cnt++;
    chk_cnt++; if (result !== 16'h0) begin fail_cnt++; $display("FAIL rst_mid_result: got %h want 0000", result); end else pass_cnt++;
    chk_cnt++; if (eng_x !== 16'h0) begin fail_cnt++; $display("FAIL rst_mid_eng_x: got %h want 0000", eng_x); end else pass_cnt++;
    rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      cyc();
      if (ack !== '0) n_ack++;
    end
    chk_cnt++; if (n_ack != 0) begin fail_cnt++; $display("FAIL rst_mid_no_ack: got %0d acks want 0", n_ack); end else pass_cnt++;
  endtask

  task automatic test_timeout();
    int s_at   = -1;
    int a_at   = -1;
    int n_ack  = 0;
    int n_bl   = 0;
    int n_gr   = 0;
    logic [15:0] r_at = 'x;
    logic        e_at = 1'bx;
    req = '0;
    eng_lat = 5;
    do_reset();
    eng_hang = 1'b1;
    x_in[0 +: 16] = 16'h3333;
    req = 4'b0001;
`ifdef EXP_ARB_TIMEOUT_EN
    for (int n = 1; n <= 60; n++) begin
      cyc();
      if (eng_start && s_at < 0) s_at = n;
      if (ack !== '0) begin
        a_at = n;
        r_at = result;
        e_at = err;
        req = '0;
        break;
      end
    end
    chk_cnt++; if (s_at < 0 || a_at != s_at + 21) begin fail_cnt++; $display("FAIL timeout_latency: ack cycle %0d want %0d", a_at, s_at + 21); end else pass_cnt++;
    chk_cnt++; if (e_at !== 1'b1) begin fail_cnt++; $display("FAIL timeout_err: got %0b want 1", e_at); end else pass_cnt++;
    chk_cnt++; if (r_at !== 16'h0) begin fail_cnt++; $display("FAIL timeout_result: got %h want 0000", r_at); end else pass_cnt++;
    cyc();
    chk_cnt++; if (dut.ptr !== 2'd1) begin fail_cnt++; $display("FAIL timeout_ptr: got %0d want 1", dut.ptr); end else pass_cnt++;
    req = 4'b0001;
    for (int n = 0; n < 10; n++) begin
      cyc();
      if (grant !== '0) n_gr++;
    end
    chk_cnt++; if (n_gr != 0) begin fail_cnt++; $display("FAIL timeout_regrant: %0d granted cycles while engine busy, want 0", n_gr); end else pass_cnt++;
`else
    for (int n = 1; n <= 60; n++) begin
      cyc();
      if (eng_start && s_at < 0) s_at = n;
      if (ack !== '0) n_ack++;
      if (s_at > 0 && n > s_at && !busy) n_bl++;
    end
    chk_cnt++; if (s_at < 0) begin fail_cnt++; $display("FAIL hang_start: no eng_start seen"); end else pass_cnt++;
    chk_cnt++; if (n_ack != 0) begin fail_cnt++; $display("FAIL hang_no_ack: got %0d acks want 0", n_ack); end else pass_cnt++;
    chk_cnt++; if (n_bl != 0) begin fail_cnt++; $display("FAIL hang_busy: busy low for %0d cycles, want 0", n_bl); end else pass_cnt++;
`endif
    req = '0;
    eng_hang = 1'b0;
    do_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_wrap();
    test_done_low();
    test_reset_mid();
    test_timeout();
    chk_cnt++; if (exp_q.size() != 0) begin fail_cnt++; $display("FAIL scoreboard_drain: %0d expected results left", exp_q.size()); end else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1, "time limit");
  end

endmodule
